iir_decim_out: RTL and testbench

- Output stage directly downstream of the parallel biquad bank. It consumes the summed filter output, one sample per clock when in_valid is high.
- Boxcar-averages and decimates by R = 2^DECIM_LOG2, then rounds and saturates the result back to DATA_WIDTH.
- Results are buffered in a small first-word-fall-through (FWFT) FIFO and drained over a valid/ready interface to the sink (DAC serializer or bus bridge).
- Flags lost samples when the sink stalls.

---
 rtl/iir_pkg.sv | 41 ++++
 rtl/iir_decim_out_if.sv | 24 ++
 rtl/iir_sync_fifo_fwft.sv | 60 ++++++
 rtl/iir_decim_out.sv | 89 ++++++++
 tb/tb_iir_decim_out.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// Shared helpers for the IIR output path: width helper, sample limits
// and the round-and-saturate used at the decimator output.
package iir_pkg;

    localparam int DW_DEFAULT = 16;
    localparam logic signed [DW_DEFAULT-1:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [DW_DEFAULT-1:0] SAMPLE_MIN = 16'sh8000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Computed at 64 bits so the rounding offset can never overflow the sum.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] s,
        input int                 sh,
        input int                 dw
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = s;
        if (sh > 0) begin
            r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
        end
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_decim_out_if.sv
// Sample-in / decimated-out handshake bundle of the IIR output stage.
interface iir_decim_out_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LVL_WIDTH  = 3
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [LVL_WIDTH-1:0]         fifo_level;
    logic                         ovf_sticky;
    logic                         clr_ovf;

    modport master (
        output in_valid, in_data, out_ready, clr_ovf,
        input  out_valid, out_data, fifo_level, ovf_sticky
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_ovf,
        output out_valid, out_data, fifo_level, ovf_sticky
    );
endinterface

// File: rtl/iir_sync_fifo_fwft.sv
// Small first-word-fall-through FIFO with extended pointers.
// The head keeps showing the last popped word while empty.
module iir_sync_fifo_fwft
    import iir_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_WIDTH  = clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [LVL_WIDTH-1:0]  level,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = LVL_WIDTH - 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] last_q;
    logic [LVL_WIDTH-1:0]  wr_q, wr_d;
    logic [LVL_WIDTH-1:0]  rd_q, rd_d;
    logic                  do_push;
    logic                  do_pop;

    assign level   = wr_q - rd_q;
    assign full    = (level == LVL_WIDTH'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign wr_d    = do_push ? wr_q + LVL_WIDTH'(1) : wr_q;
    assign rd_d    = do_pop ? rd_q + LVL_WIDTH'(1) : rd_q;

    assign head_data = empty ? last_q : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_data;
            end
            if (do_pop) begin
                last_q <= mem_q[rd_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/iir_decim_out.sv
// Boxcar-average decimator with round/saturate, buffered into an FWFT
// FIFO and drained over valid/ready; flags samples dropped on a stall.
module iir_decim_out
    import iir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    iir_decim_out_if.slave bus
);
    localparam int ACC_WIDTH = DATA_WIDTH + DECIM_LOG2;
    localparam int CNT_WIDTH = (DECIM_LOG2 > 1) ? DECIM_LOG2 : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_PH =
        CNT_WIDTH'((1 << DECIM_LOG2) - 1);

    logic [CNT_WIDTH-1:0]         phase_q, phase_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] res;
    logic                         ovf_q, ovf_d;
    logic                         last;
    logic                         push;
    logic                         pop;
    logic                         drop;
    logic                         full;
    logic                         empty;

    assign last = (phase_q == LAST_PH);
    assign sum  = acc_q + ACC_WIDTH'(bus.in_data);
    assign res  = DATA_WIDTH'(sat_round(64'(sum), DECIM_LOG2, DATA_WIDTH));
    assign push = bus.in_valid && last;
    assign pop  = bus.out_ready && !empty;
    assign drop = push && full && !pop;

    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (bus.in_valid) begin
            if (last) begin
                phase_d = '0;
                acc_d   = '0;
            end else begin
                phase_d = phase_q + CNT_WIDTH'(1);
                acc_d   = sum;
            end
        end
        // A fresh drop outranks a clear in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    iir_sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (res),
        .pop       (bus.out_ready),
        .head_data (bus.out_data),
        .level     (bus.fifo_level),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid  = !empty;
    assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_iir_decim_out.sv
// Bench for iir_decim_out: directed scenarios plus random traffic
// against a window/queue reference model.
module tb_iir_decim_out;

    localparam int DW    = 16;
    localparam int DL2   = 2;
    localparam int R     = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk;
    logic rst;

    int vec;
    int err;

    int fq[$];
    int win[$];
    bit m_ovf;
    int m_head;

    iir_decim_out_if #(.DATA_WIDTH(DW), .LVL_WIDTH(LW)) ifc ();

    iir_decim_out #(
        .DATA_WIDTH (DW),
        .DECIM_LOG2 (DL2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        fq.delete();
        win.delete();
        m_ovf  = 1'b0;
        m_head = 0;
    endtask

    // Drive one cycle, advance the reference model at the edge.
    task automatic step(input bit v, input int d, input bit rdy, input bit clr);
        bit pop;
        bit drop;
        int s;
        int r;
        ifc.in_valid  = v;
        ifc.in_data   = 16'(d);
        ifc.out_ready = rdy;
        ifc.clr_ovf   = clr;
        @(posedge clk);
        pop  = rdy && (fq.size() > 0);
        drop = 1'b0;
        if (pop) void'(fq.pop_front());
        if (v) begin
            win.push_back(d);
            if (win.size() == R) begin
                s = 0;
                foreach (win[i]) s += win[i];
                r = (s + R / 2) >>> DL2;
                if (r > 32767) r = 32767;
                if (r < -32768) r = -32768;
                win.delete();
                if (fq.size() < DEPTH) fq.push_back(r);
                else drop = 1'b1;
            end
        end
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        if (fq.size() > 0) m_head = fq[0];
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b1;
        ifc.clr_ovf   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = i[0];
            ifc.in_data  = 16'($urandom);
            @(posedge clk);
            #1;
            vec++;
            if (ifc.out_valid !== 1'b0 || ifc.fifo_level !== 3'd0 ||
                ifc.ovf_sticky !== 1'b0) begin
                err++;
                $display("FAIL reset_hold: valid=%b level=%0d ovf=%b, expected 0 0 0",
                         ifc.out_valid, ifc.fifo_level, ifc.ovf_sticky);
            end
        end
        rst = 1'b1;
        model_reset();
        step(1'b0, 0, 1'b1, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b0 || ifc.fifo_level !== 3'd0 ||
            ifc.ovf_sticky !== 1'b0 || ifc.out_data !== 16'sd0) begin
            err++;
            $display("FAIL reset_release: valid=%b level=%0d ovf=%b data=%0d, expected 0 0 0 0",
                     ifc.out_valid, ifc.fifo_level, ifc.ovf_sticky, ifc.out_data);
        end
    endtask

    task automatic test_average();
        step(1'b1, 100, 1'b1, 1'b0);
        step(1'b1, 200, 1'b1, 1'b0);
        step(1'b1, 300, 1'b1, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b0) begin
            err++;
            $display("FAIL avg_early: out_valid=%b, expected 0", ifc.out_valid);
        end
        step(1'b1, 401, 1'b1, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b1 || int'(ifc.out_data) !== 250) begin
            err++;
            $display("FAIL avg_pos: valid=%b data=%0d, expected 1 250",
                     ifc.out_valid, ifc.out_data);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b0) begin
            err++;
            $display("FAIL avg_pop: out_valid=%b, expected 0", ifc.out_valid);
        end
        step(1'b1, -1, 1'b1, 1'b0);
        step(1'b1, -1, 1'b1, 1'b0);
        step(1'b1, -1, 1'b1, 1'b0);
        step(1'b1, -2, 1'b1, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b1 || int'(ifc.out_data) !== -1) begin
            err++;
            $display("FAIL avg_neg: valid=%b data=%0d, expected 1 -1",
                     ifc.out_valid, ifc.out_data);
        end
        step(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < R; i++) step(1'b1, 32767, 1'b1, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b1 || int'(ifc.out_data) !== 32767) begin
            err++;
            $display("FAIL sat_max: valid=%b data=%0d, expected 1 32767",
                     ifc.out_valid, ifc.out_data);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < R; i++) step(1'b1, -32768, 1'b1, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b1 || int'(ifc.out_data) !== -32768) begin
            err++;
            $display("FAIL sat_min: valid=%b data=%0d, expected 1 -32768",
                     ifc.out_valid, ifc.out_data);
        end
        step(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_gapped();
        int vals[4] = '{100, 200, 300, 401};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, vals[k], 1'b1, 1'b0);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 0, 1'b1, 1'b0);
                    vec++;
                    if (ifc.out_valid !== 1'b0) begin
                        err++;
                        $display("FAIL gap_idle: out_valid=%b, expected 0",
                                 ifc.out_valid);
                    end
                end
            end
        end
        vec++;
        if (ifc.out_valid !== 1'b1 || int'(ifc.out_data) !== 250) begin
            err++;
            $display("FAIL gap_avg: valid=%b data=%0d, expected 1 250",
                     ifc.out_valid, ifc.out_data);
        end
        step(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0);
            vec++;
            if (ifc.out_valid !== (fq.size() != 0) ||
                ifc.fifo_level !== LW'(fq.size()) || ifc.ovf_sticky !== m_ovf) begin
                err++;
                $display("FAIL bp_fill: valid=%b level=%0d ovf=%b, expected %b %0d %b",
                         ifc.out_valid, ifc.fifo_level, ifc.ovf_sticky,
                         fq.size() != 0, fq.size(), m_ovf);
            end
        end
        vec++;
        if (ifc.fifo_level !== 3'd4 || ifc.ovf_sticky !== 1'b1) begin
            err++;
            $display("FAIL bp_full: level=%0d ovf=%b, expected 4 1",
                     ifc.fifo_level, ifc.ovf_sticky);
        end
        for (int i = 0; i < 5; i++) begin
            if (fq.size() != 0) begin
                vec++;
                if (int'(ifc.out_data) !== m_head) begin
                    err++;
                    $display("FAIL bp_drain_data: data=%0d, expected %0d",
                             ifc.out_data, m_head);
                end
            end
            step(1'b0, 0, 1'b1, 1'b0);
            vec++;
            if (ifc.out_valid !== (fq.size() != 0) ||
                ifc.fifo_level !== LW'(fq.size())) begin
                err++;
                $display("FAIL bp_drain: valid=%b level=%0d, expected %b %0d",
                         ifc.out_valid, ifc.fifo_level, fq.size() != 0, fq.size());
            end
        end
        step(1'b0, 0, 1'b0, 1'b1);
        vec++;
        if (ifc.ovf_sticky !== 1'b0) begin
            err++;
            $display("FAIL bp_clr: ovf=%b, expected 0", ifc.ovf_sticky);
        end
        ifc.clr_ovf = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4 * R + R - 1; i++) begin
            step(1'b1, int'($urandom_range(0, 2000)) - 1000, 1'b0, 1'b0);
        end
        vec++;
        if (ifc.fifo_level !== 3'd4) begin
            err++;
            $display("FAIL fp_pre: level=%0d, expected 4", ifc.fifo_level);
        end
        step(1'b1, int'($urandom_range(0, 2000)) - 1000, 1'b1, 1'b0);
        vec++;
        if (ifc.fifo_level !== 3'd4 || ifc.ovf_sticky !== 1'b0) begin
            err++;
            $display("FAIL fp_simul: level=%0d ovf=%b, expected 4 0",
                     ifc.fifo_level, ifc.ovf_sticky);
        end
        while (fq.size() != 0) begin
            vec++;
            if (ifc.out_valid !== 1'b1 || int'(ifc.out_data) !== m_head) begin
                err++;
                $display("FAIL fp_order: valid=%b data=%0d, expected 1 %0d",
                         ifc.out_valid, ifc.out_data, m_head);
            end
            step(1'b0, 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1000, 1'b1, 1'b0);
        step(1'b1, 1000, 1'b1, 1'b0);
        ifc.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < R; i++) step(1'b1, 8, 1'b0, 1'b0);
        vec++;
        if (ifc.out_valid !== 1'b1 || ifc.fifo_level !== 3'd1 ||
            int'(ifc.out_data) !== 8) begin
            err++;
            $display("FAIL mid_reset: valid=%b level=%0d data=%0d, expected 1 1 8",
                     ifc.out_valid, ifc.fifo_level, ifc.out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, int'($urandom_range(0, 65535)) - 32768,
                 ($urandom % 3) == 0, ($urandom % 16) == 0);
            vec++;
            if (ifc.out_valid !== (fq.size() != 0) ||
                ifc.fifo_level !== LW'(fq.size()) || ifc.ovf_sticky !== m_ovf) begin
                err++;
                $display("FAIL rand_status: cyc=%0d valid=%b level=%0d ovf=%b, expected %b %0d %b",
                         i, ifc.out_valid, ifc.fifo_level, ifc.ovf_sticky,
                         fq.size() != 0, fq.size(), m_ovf);
            end
            if (fq.size() != 0) begin
                vec++;
                if (int'(ifc.out_data) !== m_head) begin
                    err++;
                    $display("FAIL rand_data: cyc=%0d data=%0d, expected %0d",
                             i, ifc.out_data, m_head);
                end
            end
        end
    endtask

    initial begin
        vec = 0;
        err = 0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        ifc.clr_ovf   = 1'b0;
        model_reset();
        test_reset();
        test_average();
        test_saturation();
        test_gapped();
        test_backpressure();
        test_full_pop();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
